// File: rtl/ballot_session_ctrl.sv
// ballot_session_ctrl
//   Runs one-voter-one-vote sessions in front of the tally datapath. The
//   officer arms a ballot, the controller accepts a single clean candidate
//   press, issues it as a one-cycle one-hot increment strobe, then holds a
//   post-vote lockout. Also voids idle ballots on timeout and closes the poll.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   IDLE    | no ballot issued, waiting for i_ballot_en
//   ARMED   | ballot issued, waiting for a single clean press or timeout
//   COMMIT  | one cycle: strobe the captured vote, bump the total
//   LOCKOUT | post-vote hold; exits once minimum time passed and buttons free
//   CLOSED  | poll closed, terminal until rst
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   i_ballot_en     officer issues a ballot (looked at in IDLE only)
//   i_candidate     raw button levels, bit k = candidate k+1
//   i_voting_over   poll close request, latched sticky
//   o_ready         ballot armed
//   o_vote_valid    one-cycle vote strobe, o_vote_sel one-hot candidate
//   o_busy          commit/lockout in progress
//   o_timeout       one-cycle strobe: armed ballot voided
//   o_closed        poll closed
//   o_total         accepted vote count
//
// All outputs are registered from the state the FSM was in at the edge, so
// they trail the state by one cycle (ready one cycle after arming, vote strobe
// one cycle after the press is taken).

module ballot_session_ctrl #(
    parameter int N_CAND      = 3,
    parameter int CNT_W       = 6,
    parameter int LOCK_CYCLES = 4,
    parameter int TIMEOUT_CYC = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_ballot_en,
    input  logic [N_CAND-1:0] i_candidate,
    input  logic              i_voting_over,
    output logic              o_ready,
    output logic              o_vote_valid,
    output logic [N_CAND-1:0] o_vote_sel,
    output logic              o_busy,
    output logic              o_timeout,
    output logic              o_closed,
    output logic [CNT_W-1:0]  o_total
);

    localparam int TMR_MAX = (TIMEOUT_CYC > LOCK_CYCLES) ? TIMEOUT_CYC : LOCK_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam logic [TMR_W-1:0] TO_LAST   = TMR_W'(TIMEOUT_CYC - 1);
    localparam logic [TMR_W-1:0] LK_LAST   = TMR_W'(LOCK_CYCLES - 1);
    localparam logic [CNT_W-1:0] TOTAL_MAX = '1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ARMED   = 3'd1,
        S_COMMIT  = 3'd2,
        S_LOCKOUT = 3'd3,
        S_CLOSED  = 3'd4
    } state_t;

    state_t            state_q;
    logic [N_CAND-1:0] cand_q;
    logic [N_CAND-1:0] sel_q;
    logic [TMR_W-1:0]  timer_q;
    logic              close_q;

    logic [N_CAND-1:0] press;
    logic              press_ok;
    logic              close_req;

    // Rising edges only; a press counts only if it is the sole button down,
    // which rejects simultaneous presses and presses while another is held.
    assign press     = i_candidate & ~cand_q;
    assign press_ok  = $onehot(press) && (i_candidate == press);
    assign close_req = i_voting_over | close_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cand_q       <= '0;
            sel_q        <= '0;
            timer_q      <= '0;
            close_q      <= 1'b0;
            o_ready      <= 1'b0;
            o_vote_valid <= 1'b0;
            o_vote_sel   <= '0;
            o_busy       <= 1'b0;
            o_timeout    <= 1'b0;
            o_closed     <= 1'b0;
            o_total      <= '0;
        end else begin
            cand_q       <= i_candidate;
            close_q      <= close_q | i_voting_over;
            o_ready      <= (state_q == S_ARMED);
            o_busy       <= (state_q == S_COMMIT) || (state_q == S_LOCKOUT);
            o_closed     <= (state_q == S_CLOSED);
            o_vote_valid <= 1'b0;
            o_vote_sel   <= '0;
            o_timeout    <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (close_req) begin
                        state_q <= S_CLOSED;
                    end else if (i_ballot_en && (o_total != TOTAL_MAX)) begin
                        // saturated total refuses new ballots, so no wrap
                        state_q <= S_ARMED;
                        timer_q <= '0;
                    end
                end
                S_ARMED: begin
                    if (close_req) begin
                        state_q <= S_CLOSED;
                    end else if (press_ok) begin
                        state_q <= S_COMMIT;
                        sel_q   <= press;
                    end else if (timer_q == TO_LAST) begin
                        state_q   <= S_IDLE;
                        o_timeout <= 1'b1;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                S_COMMIT: begin
                    // a close request arriving now does not cancel the vote
                    o_vote_valid <= 1'b1;
                    o_vote_sel   <= sel_q;
                    o_total      <= o_total + 1'b1;
                    state_q      <= S_LOCKOUT;
                    timer_q      <= '0;
                end
                S_LOCKOUT: begin
                    if ((timer_q >= LK_LAST) && (i_candidate == '0)) begin
                        state_q <= close_req ? S_CLOSED : S_IDLE;
                    end else if (timer_q != LK_LAST) begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                S_CLOSED: begin
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule
